mem_stage: RTL and testbench

//   Pipeline MEM stage: consumer of the EXE/MEM register outputs. Drives the data-memory

---
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request/ack port, load extension, MEM forwarding value
// and the MEM/WB register. Stalls the pipe while a memory access is in flight.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_PCtoReg,
  input  logic [31:0] EXE_ALUout,
  input  logic [31:0] EXE_rs2data,
  input  logic [4:0]  EXE_rdaddr,
  input  logic [2:0]  EXE_Funct3,
  input  logic        EXE_rdsrc,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_RegWrite,
  output logic        DM_req,
  output logic [3:0]  DM_we,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_wdata,
  input  logic [31:0] DM_rdata,
  input  logic        DM_ack,
  output logic [31:0] MEM_rddata,
  output logic        MEM_stall,
  output logic        MEM_fault,
  output logic [31:0] WB_rddata,
  output logic [31:0] WB_lddata,
  output logic [4:0]  WB_rdaddr,
  output logic        WB_MemtoReg,
  output logic        WB_RegWrite
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] ld_buf, ld_ext;
  logic [3:0]  be;
  logic [1:0]  off;
  logic        mem_op, sz_b, sz_h, sz_w, misalign, ack_hit, tmo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off      = EXE_ALUout[1:0];
  assign mem_op   = EXE_MemRead | EXE_MemWrite;
  assign sz_b     = (EXE_Funct3[1:0] == 2'b00);
  assign sz_h     = (EXE_Funct3[1:0] == 2'b01);
  assign sz_w     = ~(sz_b | sz_h);
  assign misalign = mem_op & ((sz_h & off[0]) | (sz_w & (off != 2'b00)));
  assign ack_hit  = (state == ACCESS) & DM_ack;
  // ack arriving in the timeout cycle takes priority over the abort
  assign tmo      = (state == ACCESS) & ~DM_ack & (TIMEOUT_CYC != 0) &
                    (cnt == 32'(TIMEOUT_CYC - 1));

  assign MEM_rddata = EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout;
  assign DM_addr    = {EXE_ALUout[31:2], 2'b00};

  always_comb begin
    be       = 4'b1111;
    DM_wdata = EXE_rs2data;
    if (sz_b) begin
      be       = 4'b0001 << off;
      DM_wdata = {4{EXE_rs2data[7:0]}};
    end else if (sz_h) begin
      be       = 4'b0011 << {off[1], 1'b0};
      DM_wdata = {2{EXE_rs2data[15:0]}};
    end
  end
  assign DM_we = EXE_MemWrite ? be : 4'b0000;

  assign ld_byte = DM_rdata[8*off +: 8];
  assign ld_half = DM_rdata[16*off[1] +: 16];
  always_comb begin
    case (EXE_Funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = DM_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && !misalign) state_nxt = ACCESS;
      ACCESS:  if (DM_ack) state_nxt = DONE;
               else if (tmo) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    DM_req    = (state == ACCESS);
    MEM_stall = ((state == IDLE) & mem_op & ~misalign) | ((state == ACCESS) & ~tmo);
    MEM_fault = ((state == IDLE) & misalign) | tmo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      ld_buf <= '0;
    end else begin
      cnt <= (state == ACCESS) ? cnt + 32'd1 : '0;
      if (ack_hit) ld_buf <= ld_ext;
    end
  end

  // stalled or faulted instructions reach WB as bubbles; data fields hold
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_rddata   <= '0;
      WB_lddata   <= '0;
      WB_rdaddr   <= '0;
      WB_MemtoReg <= 1'b0;
      WB_RegWrite <= 1'b0;
    end else if (MEM_stall || MEM_fault) begin
      WB_MemtoReg <= 1'b0;
      WB_RegWrite <= 1'b0;
    end else begin
      WB_rddata   <= MEM_rddata;
      WB_lddata   <= ld_buf;
      WB_rdaddr   <= EXE_rdaddr;
      WB_MemtoReg <= EXE_MemtoReg;
      WB_RegWrite <= EXE_RegWrite;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drives EXE-side ops, plays the memory, and checks the port
// and WB results against a queue of expected WB entries.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXE_PCtoReg, EXE_ALUout, EXE_rs2data;
  logic [4:0]  EXE_rdaddr;
  logic [2:0]  EXE_Funct3;
  logic        EXE_rdsrc, EXE_MemRead, EXE_MemWrite, EXE_MemtoReg, EXE_RegWrite;
  logic        DM_req;
  logic [3:0]  DM_we;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic        DM_ack;
  logic [31:0] MEM_rddata;
  logic        MEM_stall, MEM_fault;
  logic [31:0] WB_rddata, WB_lddata;
  logic [4:0]  WB_rdaddr;
  logic        WB_MemtoReg, WB_RegWrite;

  typedef struct {
    logic [31:0] rddata;
    logic [31:0] lddata;
    logic [4:0]  rdaddr;
    logic        memtoreg;
    logic        regwrite;
    bit          full;
  } wb_exp_t;

  wb_exp_t sb[$];
  int vec = 0;
  int errs = 0;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .EXE_PCtoReg(EXE_PCtoReg), .EXE_ALUout(EXE_ALUout), .EXE_rs2data(EXE_rs2data),
    .EXE_rdaddr(EXE_rdaddr), .EXE_Funct3(EXE_Funct3), .EXE_rdsrc(EXE_rdsrc),
    .EXE_MemRead(EXE_MemRead), .EXE_MemWrite(EXE_MemWrite), .EXE_MemtoReg(EXE_MemtoReg),
    .EXE_RegWrite(EXE_RegWrite),
    .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
    .DM_rdata(DM_rdata), .DM_ack(DM_ack),
    .MEM_rddata(MEM_rddata), .MEM_stall(MEM_stall), .MEM_fault(MEM_fault),
    .WB_rddata(WB_rddata), .WB_lddata(WB_lddata), .WB_rdaddr(WB_rdaddr),
    .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rdx,
                       input logic m2r, input logic rw);
    EXE_MemRead  = rd;
    EXE_MemWrite = wr;
    EXE_Funct3   = f3;
    EXE_ALUout   = alu;
    EXE_rs2data  = rs2;
    EXE_rdaddr   = rdx;
    EXE_MemtoReg = m2r;
    EXE_RegWrite = rw;
    EXE_rdsrc    = 1'b0;
    EXE_PCtoReg  = 32'h0000_4000;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] rdd, input logic [31:0] ldd, input logic [4:0] rdx,
                      input logic m2r, input logic rw, input bit full);
    wb_exp_t e;
    e.rddata = rdd; e.lddata = ldd; e.rdaddr = rdx;
    e.memtoreg = m2r; e.regwrite = rw; e.full = full;
    sb.push_back(e);
  endtask

  task automatic check_wb(input string tag);
    wb_exp_t e;
    vec++;
    assert (sb.size() != 0) else begin
      errs++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_regwrite"}, 32'(WB_RegWrite), 32'(e.regwrite));
      chk({tag, "_memtoreg"}, 32'(WB_MemtoReg), 32'(e.memtoreg));
      if (e.full) begin
        chk({tag, "_rddata"}, WB_rddata, e.rddata);
        chk({tag, "_lddata"}, WB_lddata, e.lddata);
        chk({tag, "_rdaddr"}, 32'(WB_rdaddr), 32'(e.rdaddr));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    DM_ack = 1'b0;
    DM_rdata = 32'h0;
    nop();
    tick(); tick();
    settle();
    chk("rst_req", 32'(DM_req), 32'd0);
    chk("rst_stall", 32'(MEM_stall), 32'd0);
    chk("rst_fault", 32'(MEM_fault), 32'd0);
    chk("rst_wb_rddata", WB_rddata, 32'h0);
    chk("rst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
    rst = 1'b0;

    // ADD: single-cycle pass-through
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b1);
    settle();
    chk("add_fwd", MEM_rddata, 32'h0000_1234);
    chk("add_stall", 32'(MEM_stall), 32'd0);
    push(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1);
    tick();
    nop();
    settle();
    check_wb("add_wb");

    // LB 0x103, ack in the first ACCESS cycle
    drive(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b1);
    settle();
    chk("lb_idle_stall", 32'(MEM_stall), 32'd1);
    chk("lb_idle_req", 32'(DM_req), 32'd0);
    push(32'h0000_0103, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b1, 1'b1);
    tick();
    settle();
    chk("lb_acc_req", 32'(DM_req), 32'd1);
    chk("lb_acc_stall", 32'(MEM_stall), 32'd1);
    chk("lb_acc_addr", DM_addr, 32'h0000_0100);
    chk("lb_acc_we", 32'(DM_we), 32'h0);
    DM_ack = 1'b1; DM_rdata = 32'h80AA_BBCC;
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    settle();
    chk("lb_done_stall", 32'(MEM_stall), 32'd0);
    chk("lb_done_req", 32'(DM_req), 32'd0);
    tick();
    nop();
    settle();
    check_wb("lb_wb");

    // SH 0x102, ack withheld one ACCESS cycle
    drive(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0);
    settle();
    chk("sh_we", 32'(DM_we), 32'hC);
    chk("sh_wdata", DM_wdata, 32'hBEEF_BEEF);
    push(32'h0000_0102, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    chk("sh_acc1_req", 32'(DM_req), 32'd1);
    chk("sh_acc1_addr", DM_addr, 32'h0000_0100);
    tick();
    settle();
    chk("sh_acc2_req", 32'(DM_req), 32'd1);
    chk("sh_acc2_we", 32'(DM_we), 32'hC);
    chk("sh_acc2_wdata", DM_wdata, 32'hBEEF_BEEF);
    DM_ack = 1'b1;
    tick();
    DM_ack = 1'b0;
    tick();
    nop();
    settle();
    check_wb("sh_wb");

    // SB byte enables at lane 3
    drive(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h1234_56A5, 5'd0, 1'b0, 1'b0);
    settle();
    chk("sb_we", 32'(DM_we), 32'h8);
    chk("sb_wdata", DM_wdata, 32'hA5A5_A5A5);
    tick();
    DM_ack = 1'b1;
    tick();
    DM_ack = 1'b0;
    tick();
    nop();

    // LW misaligned: fault, no request, bubble
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0201, 32'h0, 5'd9, 1'b1, 1'b1);
    settle();
    chk("lw_mis_fault", 32'(MEM_fault), 32'd1);
    chk("lw_mis_req", 32'(DM_req), 32'd0);
    chk("lw_mis_stall", 32'(MEM_stall), 32'd0);
    push(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    settle();
    chk("lw_mis_fault_end", 32'(MEM_fault), 32'd0);
    chk("lw_mis_req_after", 32'(DM_req), 32'd0);
    check_wb("lw_mis_wb");

    // LHU 0x0, ack withheld: abort in the 4th ACCESS cycle
    drive(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd10, 1'b1, 1'b1);
    push(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("tmo_acc%0d_fault", i + 1), 32'(MEM_fault), 32'd0);
      chk($sformatf("tmo_acc%0d_stall", i + 1), 32'(MEM_stall), 32'd1);
      tick();
    end
    settle();
    chk("tmo_fault", 32'(MEM_fault), 32'd1);
    chk("tmo_stall", 32'(MEM_stall), 32'd0);
    tick();
    nop();
    settle();
    chk("tmo_req_after", 32'(DM_req), 32'd0);
    chk("tmo_fault_end", 32'(MEM_fault), 32'd0);
    check_wb("tmo_wb");

    // LHU 0x2, ack in 3rd ACCESS cycle: upper half zero-extended
    drive(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd11, 1'b1, 1'b1);
    push(32'h0000_0002, 32'h0000_BEEF, 5'd11, 1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    DM_ack = 1'b1; DM_rdata = 32'hBEEF_1234;
    settle();
    chk("lhu_ack3_fault", 32'(MEM_fault), 32'd0);
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    tick();
    nop();
    settle();
    check_wb("lhu_wb");

    // LH 0x0, ack in the timeout cycle wins
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0, 5'd12, 1'b1, 1'b1);
    push(32'h0, 32'hFFFF_8001, 5'd12, 1'b1, 1'b1, 1'b1);
    tick(); tick(); tick(); tick();
    DM_ack = 1'b1; DM_rdata = 32'h7777_8001;
    settle();
    chk("lh_race_fault", 32'(MEM_fault), 32'd0);
    chk("lh_race_stall", 32'(MEM_stall), 32'd1);
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    tick();
    nop();
    settle();
    check_wb("lh_race_wb");

    // LBU lane 1
    drive(1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'h0, 5'd13, 1'b1, 1'b1);
    push(32'h0000_0011, 32'h0000_00F0, 5'd13, 1'b1, 1'b1, 1'b1);
    tick();
    DM_ack = 1'b1; DM_rdata = 32'h0000_F000;
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    tick();
    nop();
    settle();
    check_wb("lbu_wb");

    // reset during ACCESS; late ack must be ignored
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd14, 1'b1, 1'b1);
    tick();
    settle();
    chk("rstacc_req_before", 32'(DM_req), 32'd1);
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    settle();
    chk("rstacc_req", 32'(DM_req), 32'd0);
    chk("rstacc_stall", 32'(MEM_stall), 32'd0);
    chk("rstacc_wb_regwrite", 32'(WB_RegWrite), 32'd0);
    chk("rstacc_wb_rddata", WB_rddata, 32'h0);
    DM_ack = 1'b1; DM_rdata = 32'hDEAD_BEEF;
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    settle();
    chk("late_ack_req", 32'(DM_req), 32'd0);
    chk("late_ack_stall", 32'(MEM_stall), 32'd0);
    chk("late_ack_fault", 32'(MEM_fault), 32'd0);
    tick();
    settle();
    chk("late_ack_lddata", WB_lddata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
